// File: rtl/vram_blit_master.sv
// Avalon-MM write master that copies the ROWS x COLS board cell array from a local
// synchronous source RAM into VGA tile memory, one read-capture-write sequence per cell.
module vram_blit_master #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int ROW_PITCH = 40,
    parameter int ADDR_W    = 12,
    parameter int SRC_AW    = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] DEST_BASE,
    output logic              BUSY,
    output logic              DONE,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic [15:0]       SRC_DATA,
    output logic              AVM_CS,
    output logic              AVM_WRITE,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic [31:0]       AVM_WRITEDATA,
    output logic [3:0]        AVM_BYTE_EN,
    input  logic              AVM_WAITREQUEST,
    output logic [2:0]        DBG_STATE
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    // Step from the last cell of a row to the first cell of the next tile row.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROW_PITCH - COLS + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] dest;
    logic              last_col;
    logic              last_cell;

    assign last_col  = (col == COL_LAST);
    assign last_cell = last_col && (row == ROW_LAST);
    assign AVM_CS    = AVM_WRITE;
    assign DBG_STATE = state;

    // Avalon handshake: a write beat transfers on any edge with AVM_WRITE=1 and
    // AVM_WAITREQUEST=0; until then AVM_ADDR, AVM_WRITEDATA and AVM_BYTE_EN are held.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            SRC_ADDR      <= '0;
            AVM_WRITE     <= 1'b0;
            AVM_ADDR      <= '0;
            AVM_WRITEDATA <= '0;
            AVM_BYTE_EN   <= 4'b0000;
            col           <= '0;
            row           <= '0;
            dest          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        dest     <= DEST_BASE;
                        col      <= '0;
                        row      <= '0;
                        SRC_ADDR <= '0;
                        BUSY     <= 1'b1;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    AVM_WRITEDATA <= {16'h0000, SRC_DATA};
                    AVM_ADDR      <= dest;
                    AVM_WRITE     <= 1'b1;
                    AVM_BYTE_EN   <= 4'b0011;
                    state         <= S_WR;
                end
                S_WR: begin
                    if (!AVM_WAITREQUEST) begin
                        AVM_WRITE   <= 1'b0;
                        AVM_BYTE_EN <= 4'b0000;
                        if (last_cell) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            SRC_ADDR <= SRC_ADDR + SRC_AW'(1);
                            if (last_col) begin
                                col  <= '0;
                                row  <= row + ROW_W'(1);
                                dest <= dest + ROW_STEP;
                            end else begin
                                col  <= col + COL_W'(1);
                                dest <= dest + ADDR_W'(1);
                            end
                            state <= S_RD;
                        end
                    end
                end
                S_FIN: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_blit_master.sv
// Bench for vram_blit_master: table of full-copy scenarios checked by a write scoreboard,
// plus a hand-written reset-during-stall sequence.
module tb_vram_blit_master;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int ROW_PITCH = 40;
    localparam int NCELLS = COLS * ROWS;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [11:0] DEST_BASE = '0;
    logic        BUSY, DONE, AVM_CS, AVM_WRITE;
    logic [7:0]  SRC_ADDR;
    logic [15:0] SRC_DATA;
    logic [11:0] AVM_ADDR;
    logic [31:0] AVM_WRITEDATA;
    logic [3:0]  AVM_BYTE_EN;
    logic        AVM_WAITREQUEST = 1'b0;
    logic [2:0]  DBG_STATE;

    vram_blit_master dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DEST_BASE(DEST_BASE),
        .BUSY(BUSY), .DONE(DONE), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
        .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WAITREQUEST(AVM_WAITREQUEST), .DBG_STATE(DBG_STATE)
    );

    always #10 CLK = ~CLK;

    // Source RAM model: synchronous read, one cycle latency.
    logic [15:0] src_mem [256];
    logic [15:0] src_q;
    always @(posedge CLK) src_q <= src_mem[SRC_ADDR];
    assign SRC_DATA = src_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [27:0] exp_q[$];
    logic [11:0] got_addr [256];
    int          wr_count = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    bit          mon_on = 1'b0;
    bit          hold_valid = 1'b0;
    logic [11:0] hold_addr;
    logic [31:0] hold_data;
    logic [3:0]  hold_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [11:0] base);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                logic [11:0] a;
                logic [15:0] d;
                a = base + 12'(r * ROW_PITCH + c);
                d = 16'hA500 | 16'(r * COLS + c);
                exp_q.push_back({a, d});
            end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (AVM_CS !== AVM_WRITE) chk("cs_eq_write", {31'd0, AVM_CS}, {31'd0, AVM_WRITE});
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE === 1'b1) begin
                done_count++;
                done_cyc = cyc;
            end
            if (AVM_WRITE === 1'b1) begin
                chk("wr_byte_en", {28'd0, AVM_BYTE_EN}, 32'h3);
                if (hold_valid) begin
                    chk("hold_addr", {20'd0, AVM_ADDR}, {20'd0, hold_addr});
                    chk("hold_data", AVM_WRITEDATA, hold_data);
                    chk("hold_be", {28'd0, AVM_BYTE_EN}, {28'd0, hold_be});
                end
                if (AVM_WAITREQUEST) begin
                    hold_valid = 1'b1;
                    hold_addr  = AVM_ADDR;
                    hold_data  = AVM_WRITEDATA;
                    hold_be    = AVM_BYTE_EN;
                end else begin
                    hold_valid = 1'b0;
                    if (wr_count < 256) got_addr[wr_count] = AVM_ADDR;
                    wr_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_write: got addr %0h, no write expected", AVM_ADDR);
                    end else begin
                        logic [27:0] e;
                        e = exp_q.pop_front();
                        chk("wr_addr", {20'd0, AVM_ADDR}, {20'd0, e[27:16]});
                        chk("wr_data", AVM_WRITEDATA, {16'h0000, e[15:0]});
                    end
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_write"}, {31'd0, AVM_WRITE}, 32'd0);
        chk({tag, "_cs"}, {31'd0, AVM_CS}, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_done"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_addr"}, {20'd0, AVM_ADDR}, 32'd0);
        chk({tag, "_wdata"}, AVM_WRITEDATA, 32'd0);
        chk({tag, "_be"}, {28'd0, AVM_BYTE_EN}, 32'd0);
        chk({tag, "_srcaddr"}, {24'd0, SRC_ADDR}, 32'd0);
        chk({tag, "_state"}, {29'd0, DBG_STATE}, 32'd0);
    endtask

    typedef struct {
        logic [11:0] base;
        int          stall_idx;
        int          stall_len;
        bit          rand_wait;
        int          restart_at;
        bit          start_in_done;
        logic [11:0] exp_a0;
        logic [11:0] exp_a9;
        logic [11:0] exp_a10;
        logic [11:0] exp_alast;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    // Called at posedge+1 with all inputs idle; returns at posedge+1.
    task automatic run_copy(input vec_t v);
        int t0;
        int tail;
        int stall_rem;
        bit restarted;
        wr_count   = 0;
        done_count = 0;
        busy_cnt   = 0;
        tail       = 0;
        stall_rem  = v.stall_len;
        restarted  = 1'b0;
        DEST_BASE  = v.base;
        START      = 1'b1;
        push_expected(v.base);
        @(posedge CLK); #1;
        t0    = cyc;
        START = 1'b0;
        for (int n = 0; n < 6000 && tail < 6; n++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (v.stall_idx >= 0 && AVM_WRITE === 1'b1 && wr_count == v.stall_idx && stall_rem > 0) begin
                AVM_WAITREQUEST = 1'b1;
                stall_rem--;
            end else if (v.rand_wait) begin
                AVM_WAITREQUEST = ($urandom_range(0, 3) == 0);
            end else begin
                AVM_WAITREQUEST = 1'b0;
            end
            if (v.restart_at >= 0 && !restarted && wr_count == v.restart_at) begin
                START     = 1'b1;
                DEST_BASE = 12'h555;
                restarted = 1'b1;
            end
            if (v.start_in_done && DONE === 1'b1) begin
                START     = 1'b1;
                DEST_BASE = 12'($urandom_range(0, 4095));
            end
            if (done_count > 0) tail++;
        end
        START = 1'b0;
        AVM_WAITREQUEST = 1'b0;
        if (done_count == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no DONE after base %0h, writes seen %0d", v.base, wr_count);
        end
        chk("write_count", wr_count, NCELLS);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_count, 1);
        chk("addr_first", {20'd0, got_addr[0]}, {20'd0, v.exp_a0});
        chk("addr_cell_0_9", {20'd0, got_addr[9]}, {20'd0, v.exp_a9});
        chk("addr_cell_1_0", {20'd0, got_addr[10]}, {20'd0, v.exp_a10});
        chk("addr_last", {20'd0, got_addr[NCELLS-1]}, {20'd0, v.exp_alast});
        chk("busy_after", {31'd0, BUSY}, 32'd0);
        if (v.exp_lat != 0) begin
            chk("done_latency", done_cyc - t0 + 1, v.exp_lat);
            chk("busy_cycles", busy_cnt, v.exp_lat - 1);
        end
        exp_q.delete();
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        for (int i = 0; i < 256; i++) src_mem[i] = 16'hA500 | 16'(i);

        //             base    stall  len rand restart sid  a0      a9      a10     alast   lat
        vecs[0] = '{12'h0F6, -1, 0, 1'b0, -1, 1'b0, 12'h0F6, 12'h0FF, 12'h11E, 12'h3F7, 601};
        vecs[1] = '{12'h0F6,  2, 5, 1'b0, -1, 1'b0, 12'h0F6, 12'h0FF, 12'h11E, 12'h3F7, 606};
        vecs[2] = '{12'hFF0, -1, 0, 1'b0, -1, 1'b0, 12'hFF0, 12'hFF9, 12'h018, 12'h2F1, 601};
        vecs[3] = '{12'h0F6, -1, 0, 1'b0, 50, 1'b1, 12'h0F6, 12'h0FF, 12'h11E, 12'h3F7, 601};
        vecs[4] = '{12'h3A0, -1, 0, 1'b1, -1, 1'b0, 12'h3A0, 12'h3A9, 12'h3C8, 12'h6A1, 0};

        // Clock/reset block
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs("por");
        RESET  = 1'b0;
        mon_on = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 5; i++) begin
            run_copy(vecs[i]);
            repeat (3) @(posedge CLK);
            #1;
        end

        // Reset while write 77 is stalled: the copy is abandoned without a DONE pulse.
        wr_count   = 0;
        done_count = 0;
        reached    = 1'b0;
        DEST_BASE  = 12'h100;
        START      = 1'b1;
        push_expected(12'h100);
        @(posedge CLK); #1;
        START = 1'b0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            @(posedge CLK); #1;
            if (AVM_WRITE === 1'b1 && wr_count == 76) begin
                AVM_WAITREQUEST = 1'b1;
                reached = 1'b1;
            end
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("FAIL rst_reach_write77: got %0d writes, required 76 before stall", wr_count);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk_reset_outputs("midrst");
        RESET = 1'b0;
        AVM_WAITREQUEST = 1'b0;
        exp_q.delete();
        repeat (20) @(posedge CLK);
        #1;
        chk("midrst_no_done", done_count, 0);
        chk("midrst_writes", wr_count, 76);
        chk("midrst_idle", {29'd0, DBG_STATE}, 32'd0);

        run_copy(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
